fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's async FIFO among NUM_REQ packet sources in the write-clock domain.
- Uses round-robin arbitration with a grant locked for a whole packet, so packets never interleave in the FIFO.
- Gates every beat against the FIFO full flag.
- Reports completed-packet length and source, and flags oversize packets.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, beat width; matches the FIFO DATA_WIDTH
- MAX_PKT, 16, maximum legal packet length in beats; longer packets raise pkt_oversize

Ports:
- clk  input  1  write-side clock (same clock as the FIFO wclk)
- rst  input  1  synchronous reset, active-high
- req_valid  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester last beat of packet
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester beat accepted
- fifo_full  input  1  FIFO full flag
- fifo_w_en  output  1  FIFO write enable
- fifo_w_data  output  DATA_WIDTH  FIFO write data
- busy  output  1  a grant is held
- grant_id  output  $clog2(NUM_REQ)  currently or last granted requester
- pkt_done  output  1  one-cycle pulse when a packet completes
- pkt_len  output  $clog2(MAX_PKT+1)+1  length of the completed packet, valid with pkt_done
- pkt_oversize  output  1  sticky flag: some packet exceeded MAX_PKT beats

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, beat_cnt=0.
  - busy, pkt_done, pkt_len and pkt_oversize all 0.
  - req_ready and fifo_w_en are 0 while state=IDLE.
  - Reset mid-packet aborts the grant. Beats already written stay in the FIFO; no pkt_done is emitted.
- States:
  - IDLE: if any req_valid, pick the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Register it into grant_id and go to GRANT. Arbitration costs one cycle; no beat moves in IDLE.
  - GRANT: busy=1; only requester grant_id may transfer.
- Beat path (combinational in GRANT, g = grant_id):
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - fifo_w_en = req_valid[g] && !fifo_full.
  - fifo_w_data = req_data slice g, driven in every state; only meaningful with fifo_w_en.
  - A transfer occurs when fifo_w_en=1.
  - Rule: fifo_w_en must never be 1 while fifo_full=1.
- Beat counting:
  - On each transfer, beat_cnt increments and saturates at all-ones.
  - If a transfer takes the count past MAX_PKT, pkt_oversize is set. It clears only on reset.
  - The packet still passes through unchanged.
- Packet end:
  - Triggered by a transfer with req_last[g]=1.
  - Next cycle: pkt_done=1, pkt_len=beat_cnt+1 (the count including this beat), rr_ptr=g, beat_cnt=0, state=IDLE.
  - Consequence: one bubble cycle between packets, even when requests are back to back.
- Stalls:
  - fifo_full high holds the grant with no transfer and no count change.
  - req_valid[g] low also holds the grant; there is no timeout.
- Other requesters:
  - Their req_valid/req_last are ignored during GRANT.
  - They must hold their data; the block never drops a beat.
- Single-beat packet: valid and last in the same beat gives pkt_len=1.
- Fairness: the granted source becomes the lowest priority for the next arbitration.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 for 10 cycles -> fifo_w_en=0, busy=0, req_ready=0, pkt_oversize=0 throughout.
- Single source: req 2 sends a 3-beat packet {0xA1,0xA2,0xA3} with last on 0xA3 -> busy rises 1 cycle after valid; FIFO receives A1,A2,A3 on consecutive cycles; pkt_done with pkt_len=3 and grant_id=2; back to IDLE.
- Round robin: all 4 requesters continuously present 2-beat packets -> grant order 0,1,2,3,0; 1 idle cycle between packets; no interleaving in the FIFO data stream.
- Full backpressure: fifo_full=1 for cycles 3-6 mid-packet from req 1 -> fifo_w_en=0 and req_ready[1]=0 during stall; beats resume in order; pkt_len correct.
- Oversize: req 0 sends 18 beats with MAX_PKT=16 -> pkt_oversize sets on the 17th transfer; pkt_len=18; flag stays set for later packets until rst.
- Reset mid-packet: rst asserted after 2 of 5 beats -> next cycle busy=0, no pkt_done; the next arbitration starts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-locked arbiter for the async FIFO write port
//
// Purpose: lets NUM_REQ packet sources share one FIFO write port. A grant is held
// for a whole packet so packets never interleave; every beat is gated by fifo_full.
//
// Ports:
//   clk, rst         write-side clock, synchronous active-high reset
//   req_valid/last   per-requester beat valid and end-of-packet marker
//   req_data         packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready        per-requester beat accepted (only the granted source)
//   fifo_full        FIFO full flag
//   fifo_w_en/data   FIFO write strobe and data
//   busy, grant_id   grant held / current or last granted requester
//   pkt_done/len     one-cycle completion pulse with packet length
//   pkt_oversize     sticky: some packet was longer than MAX_PKT beats

module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_PKT    = 16,
   localparam int IW        = $clog2(NUM_REQ),
   localparam int LW        = $clog2(MAX_PKT + 1) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic                          busy,
   output logic [IW-1:0]                 grant_id,
   output logic                          pkt_done,
   output logic [LW-1:0]                 pkt_len,
   output logic                          pkt_oversize
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          state_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   grant_id_q;
   logic [LW-1:0]   beat_cnt_q;
   logic [LW-1:0]   beat_cnt_d;
   logic            pkt_done_q;
   logic [LW-1:0]   pkt_len_q;
   logic            oversize_q;

   logic [IW-1:0]   arb_pick;
   logic            arb_found;
   logic            g_valid;
   logic            g_last;

   // Round-robin search starting just after rr_ptr. Descending loops leave the
   // lowest matching index; the second pass (indices above rr_ptr) overrides the
   // wrapped-around first pass, giving rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (IW'(i) <= rr_ptr_q)) begin
            arb_found = 1'b1;
            arb_pick  = IW'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (IW'(i) > rr_ptr_q)) begin
            arb_found = 1'b1;
            arb_pick  = IW'(i);
         end
      end
   end

   // Beat path: mux the granted requester onto the FIFO port.
   always_comb begin
      g_valid     = 1'b0;
      g_last      = 1'b0;
      req_ready   = '0;
      fifo_w_data = req_data[DATA_WIDTH-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == IW'(i)) begin
            g_valid      = req_valid[i];
            g_last       = req_last[i];
            fifo_w_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            req_ready[i] = (state_q == S_GRANT) && !fifo_full;
         end
      end
      fifo_w_en = (state_q == S_GRANT) && g_valid && !fifo_full;
   end

   // Saturating count including the beat currently transferring.
   assign beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= IW'(NUM_REQ - 1);
         grant_id_q <= '0;
         beat_cnt_q <= '0;
         pkt_done_q <= 1'b0;
         pkt_len_q  <= '0;
         oversize_q <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (arb_found) begin
                  grant_id_q <= arb_pick;
                  state_q    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (fifo_w_en) begin
                  if (beat_cnt_d > LW'(MAX_PKT)) begin
                     oversize_q <= 1'b1;
                  end
                  if (g_last) begin
                     // Granted source drops to lowest priority for the next round.
                     pkt_done_q <= 1'b1;
                     pkt_len_q  <= beat_cnt_d;
                     rr_ptr_q   <= grant_id_q;
                     beat_cnt_q <= '0;
                     state_q    <= S_IDLE;
                  end else begin
                     beat_cnt_q <= beat_cnt_d;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy         = (state_q == S_GRANT);
   assign grant_id     = grant_id_q;
   assign pkt_done     = pkt_done_q;
   assign pkt_len      = pkt_len_q;
   assign pkt_oversize = oversize_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MP = 16;
   localparam int IW = 2;
   localparam int LW = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_last;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             fifo_full;
   logic             fifo_w_en;
   logic [DW-1:0]    fifo_w_data;
   logic             busy;
   logic [IW-1:0]    grant_id;
   logic             pkt_done;
   logic [LW-1:0]    pkt_len;
   logic             pkt_oversize;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT(MP)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data),
      .busy(busy), .grant_id(grant_id),
      .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_oversize(pkt_oversize)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [8:0]  src_q [NR][$];   // {last, data} per source
   logic [7:0]  exp_q [$];       // expected FIFO write stream
   logic [15:0] exp_pkt [$];     // {grant id, length}
   logic [NR-1:0] acc = '0;

   // Source model: present queue heads, pop what was accepted.
   initial begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         #2;
         for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
               req_valid[i]        = 1'b1;
               req_last[i]         = src_q[i][0][8];
               req_data[i*DW +: DW] = src_q[i][0][7:0];
            end else begin
               req_valid[i]        = 1'b0;
               req_last[i]         = 1'b0;
               req_data[i*DW +: DW] = '0;
            end
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      logic [7:0]  e;
      logic [15:0] p;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (fifo_w_en) begin
            total++;
            if (fifo_full !== 1'b0) begin
               bad++;
               $display("FAIL w_en_while_full fifo_full=%b want=0", fifo_full);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat data=%h want=none", fifo_w_data);
            end else begin
               e = exp_q.pop_front();
               if (fifo_w_data !== e) begin
                  bad++;
                  $display("FAIL beat_data got=%h want=%h", fifo_w_data, e);
               end
            end
         end
         if (pkt_done) begin
            total++;
            if (exp_pkt.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pkt_done id=%0d len=%0d want=none", grant_id, pkt_len);
            end else begin
               p = exp_pkt.pop_front();
               if ({8'(grant_id), 8'(pkt_len)} !== p) begin
                  bad++;
                  $display("FAIL pkt_info got id=%0d len=%0d want id=%0d len=%0d",
                           grant_id, pkt_len, p[15:8], p[7:0]);
               end
            end
         end
      end
   end

   task automatic load_pkt(input int s, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         src_q[s].push_back({(k == n - 1), base + 8'(k)});
         exp_q.push_back(base + 8'(k));
      end
      exp_pkt.push_back({8'(s), 8'(n)});
   endtask

   task automatic drain();
      int c = 0;
      while ((exp_q.size() != 0 || exp_pkt.size() != 0) && c < 100) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (exp_q.size() != 0 || exp_pkt.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout beats_left=%0d pkts_left=%0d want=0", exp_q.size(), exp_pkt.size());
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy, fifo_w_en, req_ready, pkt_done, pkt_oversize} !== '0) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0", {busy, fifo_w_en, req_ready, pkt_done, pkt_oversize});
      end
      total++;
      if (pkt_len !== '0 || grant_id !== '0) begin
         bad++;
         $display("FAIL reset_len_id got len=%0d id=%0d want 0 0", pkt_len, grant_id);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if ({fifo_w_en, busy, req_ready, pkt_oversize} !== '0) begin
            bad++;
            $display("FAIL idle_quiet cycle=%0d got=%b want=0", c, {fifo_w_en, busy, req_ready, pkt_oversize});
         end
      end
   endtask

   task automatic test_single_source();
      @(posedge clk); #2;
      load_pkt(2, 3, 8'hA1);
      #2;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL single_busy_early got=%b want=0", busy);
      end
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #2;
         @(negedge clk);
         total++;
         if (busy !== (c <= 3) || fifo_w_en !== (c <= 3) || pkt_done !== (c == 4)) begin
            bad++;
            $display("FAIL single_timing cycle=%0d got busy=%b w_en=%b done=%b want %b %b %b",
                     c, busy, fifo_w_en, pkt_done, c <= 3, c <= 3, c == 4);
         end
         total++;
         if (req_ready !== ((c <= 3) ? 4'b0100 : 4'b0000)) begin
            bad++;
            $display("FAIL single_ready cycle=%0d got=%b want=%b", c, req_ready, (c <= 3) ? 4'b0100 : 4'b0000);
         end
      end
      drain();
   endtask

   task automatic test_round_robin();
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      load_pkt(0, 2, 8'h00);
      load_pkt(1, 2, 8'h10);
      load_pkt(2, 2, 8'h20);
      load_pkt(3, 2, 8'h30);
      load_pkt(0, 2, 8'h40);
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #2;
         @(negedge clk);
         total++;
         if (fifo_w_en !== (c % 3 != 0) || pkt_done !== (c % 3 == 0)) begin
            bad++;
            $display("FAIL rr_bubble cycle=%0d got w_en=%b done=%b want %b %b",
                     c, fifo_w_en, pkt_done, c % 3 != 0, c % 3 == 0);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      bit on;
      @(posedge clk); #2;
      load_pkt(1, 6, 8'hB0);
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #2;
         fifo_full = (c >= 3 && c <= 6);
         @(negedge clk);
         on = (c <= 2) || (c >= 7 && c <= 10);
         total++;
         if (fifo_w_en !== on || req_ready !== (on ? 4'b0010 : 4'b0000)) begin
            bad++;
            $display("FAIL stall cycle=%0d got w_en=%b ready=%b want %b %b",
                     c, fifo_w_en, req_ready, on, on ? 4'b0010 : 4'b0000);
         end
         total++;
         if (busy !== (c <= 10)) begin
            bad++;
            $display("FAIL stall_busy cycle=%0d got=%b want=%b", c, busy, c <= 10);
         end
      end
      fifo_full = 1'b0;
      drain();
   endtask

   task automatic test_oversize();
      @(posedge clk); #2;
      load_pkt(0, 18, 8'hC0);
      for (int c = 1; c <= 19; c++) begin
         @(posedge clk); #2;
         @(negedge clk);
         total++;
         if (pkt_oversize !== (c >= 18) || fifo_w_en !== (c <= 18)) begin
            bad++;
            $display("FAIL oversize cycle=%0d got flag=%b w_en=%b want %b %b",
                     c, pkt_oversize, fifo_w_en, c >= 18, c <= 18);
         end
      end
      drain();
      @(posedge clk); #2;
      load_pkt(3, 1, 8'hD0);
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk); #2;
         @(negedge clk);
         total++;
         if (fifo_w_en !== (c == 1) || pkt_done !== (c == 2)) begin
            bad++;
            $display("FAIL one_beat cycle=%0d got w_en=%b done=%b want %b %b",
                     c, fifo_w_en, pkt_done, c == 1, c == 2);
         end
      end
      total++;
      if (pkt_len !== 6'd1 || pkt_oversize !== 1'b1) begin
         bad++;
         $display("FAIL one_beat_len got len=%0d flag=%b want 1 1", pkt_len, pkt_oversize);
      end
      drain();
   endtask

   task automatic test_reset_mid_packet();
      @(posedge clk); #2;
      src_q[2].push_back({1'b0, 8'hE0});
      src_q[2].push_back({1'b0, 8'hE1});
      exp_q.push_back(8'hE0);
      exp_q.push_back(8'hE1);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #2;
         @(negedge clk);
         total++;
         if (busy !== 1'b1 || fifo_w_en !== (c <= 2)) begin
            bad++;
            $display("FAIL mid_pre cycle=%0d got busy=%b w_en=%b want 1 %b", c, busy, fifo_w_en, c <= 2);
         end
      end
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || pkt_done !== 1'b0 || grant_id !== '0 || fifo_w_en !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got busy=%b done=%b id=%0d w_en=%b want 0 0 0 0",
                  busy, pkt_done, grant_id, fifo_w_en);
      end
      @(posedge clk); #2;
      load_pkt(0, 1, 8'hF0);
      load_pkt(3, 1, 8'hF3);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #2;
         @(negedge clk);
         total++;
         if (fifo_w_en !== (c == 1 || c == 3) || pkt_done !== (c == 2 || c == 4)) begin
            bad++;
            $display("FAIL mid_rearb cycle=%0d got w_en=%b done=%b want %b %b",
                     c, fifo_w_en, pkt_done, c == 1 || c == 3, c == 2 || c == 4);
         end
      end
      drain();
   endtask

   initial begin
      rst       = 1'b1;
      fifo_full = 1'b0;
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_oversize();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
